// File: rtl/vid_timing_monitor.sv
`timescale 1ns/1ps
// vid_timing_monitor
//   On-chip video timing and frame-signature monitor. Taps the pixel stream
//   (syncs, display enable, pixel word) and, after a start request, measures
//   horizontal total, vertical total and active-pixel count for a
//   programmable number of frames.
//
//   Optional feature macro: VIDMON_CRC_EN
//     defined   -> CRC-16-CCITT (poly 0x1021, seed 0xFFFF, MSB-first, one full
//                  pixel word per step) over each frame's active pixels drives
//                  frame_crc.
//     undefined -> no CRC datapath is built and frame_crc is tied to 0.
//
//   Frame boundaries are vsync leading edges. A tick that carries the vsync
//   leading edge belongs to the frame it completes: a coincident hsync edge is
//   counted into vtotal, and a de=1 pixel on that tick is counted (and CRC'd)
//   into the completing frame. Measurement state only moves on pix_en cycles.
module vid_timing_monitor #(
    parameter int COLOR_BITS  = 4,
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = 12,
    parameter int HSYNC_POL   = 0,
    parameter int VSYNC_POL   = 0,
    parameter int MAXFRAMES_W = 4
) (
    input  logic                         sys_clk,
    input  logic                         sys_reset,
    input  logic                         pix_en,
    input  logic                         hsync,
    input  logic                         vsync,
    input  logic                         de,
    input  logic [COLOR_BITS*NUM_CH-1:0] pix,
    input  logic                         start,
    input  logic [MAXFRAMES_W-1:0]       nframes,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             htotal,
    output logic [CNT_W-1:0]             vtotal,
    output logic [2*CNT_W-1:0]           active_px,
    output logic [15:0]                  frame_crc,
    output logic                         overflow
);

    localparam int PIX_W = COLOR_BITS * NUM_CH;
    localparam int ACT_W = 2 * CNT_W;

    // Active levels of the syncs as seen on the pins.
    localparam logic HS_ACT = (HSYNC_POL != 0);
    localparam logic VS_ACT = (VSYNC_POL != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;

    // Saturating increment for line/pixel counters; MSB of result flags an
    // attempted increment past all-ones.
    function automatic logic [CNT_W:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        if (&v) begin
            return {1'b1, v};
        end
        return {1'b0, v + CNT_W'(1)};
    endfunction

    // Same for the wider active-pixel counter.
    function automatic logic [ACT_W:0] sat_inc_act(input logic [ACT_W-1:0] v);
        if (&v) begin
            return {1'b1, v};
        end
        return {1'b0, v + ACT_W'(1)};
    endfunction

    // Control state
    logic [1:0]             state;
    logic [MAXFRAMES_W-1:0] frm_left;
    logic                   hs_prev;
    logic                   vs_prev;

    // Measurement datapath (no reset: cleared when a capture arms)
    logic [CNT_W-1:0]       hcnt;
    logic [CNT_W-1:0]       vcnt;
    logic [ACT_W-1:0]       act;
    logic [CNT_W-1:0]       hsh;

    logic                   hs_edge;
    logic                   vs_edge;
    logic                   meas_tick;
    logic                   arm_go;
    logic [CNT_W:0]         hinc;
    logic [CNT_W:0]         vinc;
    logic [ACT_W:0]         ainc;
    logic [CNT_W-1:0]       vcnt_nx;
    logic [ACT_W-1:0]       act_nx;
    logic [CNT_W-1:0]       htot_nx;
    logic                   ovf_evt;

    // Leading edges: active now, inactive at the previous pix_en sample.
    assign hs_edge   = pix_en && (hsync == HS_ACT) && (hs_prev != HS_ACT);
    assign vs_edge   = pix_en && (vsync == VS_ACT) && (vs_prev != VS_ACT);
    assign meas_tick = pix_en && (state == S_MEAS);
    assign arm_go    = (state == S_ARM) && vs_edge;

    assign hinc    = sat_inc_cnt(hcnt);
    assign vinc    = sat_inc_cnt(vcnt);
    assign ainc    = sat_inc_act(act);

    // Values including this tick's contribution; used both to advance the
    // counters and to publish a completing frame.
    assign vcnt_nx = hs_edge ? vinc[CNT_W-1:0] : vcnt;
    assign act_nx  = de ? ainc[ACT_W-1:0] : act;
    assign htot_nx = hs_edge ? hcnt : hsh;

    // Any counter asked to step beyond all-ones during measurement.
    assign ovf_evt = meas_tick &&
                     ((!hs_edge && hinc[CNT_W]) ||
                      (hs_edge && vinc[CNT_W]) ||
                      (de && ainc[ACT_W]));

    // Measurement counters: cleared on the arming vsync edge, advanced per pix_en.
    always_ff @(posedge sys_clk) begin
        if (arm_go) begin
            hcnt <= CNT_W'(1);
            vcnt <= '0;
            act  <= '0;
            hsh  <= '0;
        end else if (meas_tick) begin
            hcnt <= hs_edge ? CNT_W'(1) : hinc[CNT_W-1:0];
            hsh  <= htot_nx;
            vcnt <= vs_edge ? '0 : vcnt_nx;
            act  <= vs_edge ? '0 : act_nx;
        end
    end

    // Capture FSM, sync history, sticky overflow and published results.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state     <= S_IDLE;
            frm_left  <= '0;
            hs_prev   <= ~HS_ACT;
            vs_prev   <= ~VS_ACT;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            htotal    <= '0;
            vtotal    <= '0;
            active_px <= '0;
        end else begin
            done <= 1'b0;
            if (pix_en) begin
                hs_prev <= hsync;
                vs_prev <= vsync;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        frm_left <= (nframes == '0) ? MAXFRAMES_W'(1) : nframes;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (vs_edge) begin
                        state <= S_MEAS;
                    end
                end
                S_MEAS: begin
                    if (ovf_evt) begin
                        overflow <= 1'b1;
                    end
                    if (vs_edge) begin
                        htotal    <= htot_nx;
                        vtotal    <= vcnt_nx;
                        active_px <= act_nx;
                        done      <= 1'b1;
                        frm_left  <= frm_left - MAXFRAMES_W'(1);
                        if (frm_left == MAXFRAMES_W'(1)) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef VIDMON_CRC_EN
    // One CRC-16-CCITT step over a whole pixel word, MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [PIX_W-1:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = PIX_W - 1; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    logic [15:0] crc;
    logic [15:0] crc_nx;

    assign crc_nx = de ? crc_step(crc, pix) : crc;

    // Running CRC: reseeded at every frame boundary, absorbs de=1 pixels.
    always_ff @(posedge sys_clk) begin
        if (arm_go || (meas_tick && vs_edge)) begin
            crc <= 16'hFFFF;
        end else if (meas_tick) begin
            crc <= crc_nx;
        end
    end

    // Published CRC of the last completed frame.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            frame_crc <= '0;
        end else if (meas_tick && vs_edge) begin
            frame_crc <= crc_nx;
        end
    end
`else
    // Pixel data only feeds the CRC; without it the word is intentionally dropped.
    logic crc_unused;
    assign crc_unused = ^pix;
    assign frame_crc  = '0;
`endif

endmodule

// File: tb/tb_vid_timing_monitor.sv
`timescale 1ns/1ps
// Bench for vid_timing_monitor: generates parameterised raster timing with
// random pixel data and pix_en duty, and compares every done pulse against
// values derived from the raster geometry and a word-wise CRC model.
module tb_vid_timing_monitor;

    localparam int   PW = 12;
    localparam int   CW = 12;
    localparam int   MW = 4;
    localparam logic HP = 1'b0;
    localparam logic VP = 1'b0;

    logic            sys_clk   = 1'b0;
    logic            sys_reset = 1'b1;
    logic            pix_en    = 1'b0;
    logic            hsync     = ~HP;
    logic            vsync     = ~VP;
    logic            de        = 1'b0;
    logic [PW-1:0]   pix       = '0;
    logic            start     = 1'b0;
    logic [MW-1:0]   nframes   = '0;
    logic            busy;
    logic            done;
    logic [CW-1:0]   htotal;
    logic [CW-1:0]   vtotal;
    logic [2*CW-1:0] active_px;
    logic [15:0]     frame_crc;
    logic            overflow;

    vid_timing_monitor #(
        .COLOR_BITS (4),
        .NUM_CH     (3),
        .CNT_W      (CW),
        .HSYNC_POL  (0),
        .VSYNC_POL  (0),
        .MAXFRAMES_W(MW)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .pix_en   (pix_en),
        .hsync    (hsync),
        .vsync    (vsync),
        .de       (de),
        .pix      (pix),
        .start    (start),
        .nframes  (nframes),
        .busy     (busy),
        .done     (done),
        .htotal   (htotal),
        .vtotal   (vtotal),
        .active_px(active_px),
        .frame_crc(frame_crc),
        .overflow (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    longint cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [CW-1:0]   ht;
        logic [CW-1:0]   vt;
        logic [2*CW-1:0] ap;
        logic [15:0]     crc;
        logic            bsy;
        longint          cy;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   ndone = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // CRC-16-CCITT reference: xor the word under the top of the register,
    // then clock out its bits with polynomial reduction.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [PW-1:0] w);
        int r;
        r = int'(c) ^ (int'(w) << (16 - PW));
        for (int i = 0; i < PW; i++) begin
            r = r << 1;
            if ((r & 'h10000) != 0) r = r ^ 'h11021;
        end
        return 16'(r);
    endfunction

    // Scoreboard: every done pulse must match the oldest expected frame.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_reset && done) begin
            ndone++;
            if (expq.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                e = expq.pop_front();
                check("htotal", htotal, e.ht);
                check("vtotal", vtotal, e.vt);
                check("active_px", active_px, e.ap);
                check("frame_crc", frame_crc, e.crc);
                check("busy_at_done", busy, e.bsy);
                check("done_cycle", cyc, e.cy);
            end
        end
    end

    // One pixel tick spread over div sys_clk cycles; only the last carries
    // pix_en, the others drive junk that must be ignored.
    task automatic tick(input logic hs_a, input logic vs_a, input logic d,
                        input logic [PW-1:0] p, input logic st, input int div,
                        output longint ec);
        for (int k = 0; k < div; k++) begin
            @(negedge sys_clk);
            start = 1'b0;
            if (k == div - 1) begin
                pix_en = 1'b1;
                hsync  = hs_a ? HP : ~HP;
                vsync  = vs_a ? VP : ~VP;
                de     = d;
                pix    = p;
                start  = st;
                ec     = cyc + 1;
            end else begin
                pix_en = 1'b0;
                hsync  = 1'($urandom);
                vsync  = 1'($urandom);
                de     = 1'($urandom);
                pix    = PW'($urandom);
            end
        end
    endtask

    task automatic pulse_start(input int nf);
        @(negedge sys_clk);
        pix_en  = 1'b0;
        hsync   = ~HP;
        vsync   = ~VP;
        de      = 1'b0;
        start   = 1'b1;
        nframes = MW'(nf);
        @(negedge sys_clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("overflow_cleared", overflow, 0);
    endtask

    task automatic run_case(input int hlen, input int hsw, input int hde0, input int hdel,
                            input int vlen, input int vsw, input int vde0, input int vdel,
                            input int div, input int nfr, input int pre, input int cpix,
                            input int abort_run);
        int          nfe;
        int          base;
        int          lines;
        int          acc_n;
        logic [15:0] acc_crc;
        logic        aborted;
        logic        d;
        logic        st;
        logic [PW-1:0] p;
        longint      ec;
        exp_t        e;

        nfe     = (nfr == 0) ? 1 : nfr;
        base    = ndone;
        aborted = 1'b0;
        acc_n   = 0;
        acc_crc = 16'hFFFF;
        pulse_start(nfr);

        // Partial raster before the first vsync edge: must be discarded.
        for (int l = 0; l < pre; l++)
            for (int t = 0; t < hlen; t++)
                tick(t < hsw, 1'b0, 1'($urandom), PW'($urandom), 1'b0, div, ec);

        for (int f = 0; f <= nfe; f++) begin
            lines = (f == nfe) ? 1 : vlen;
            for (int l = 0; l < lines; l++) begin
                for (int t = 0; t < hlen; t++) begin
                    if (abort_run != 0 && f == 1 && l == 1 && t == 0 && !aborted) begin
                        @(negedge sys_clk);
                        sys_reset = 1'b1;
                        #1;
                        check("rst_busy", busy, 0);
                        check("rst_done", done, 0);
                        check("rst_htotal", htotal, 0);
                        check("rst_vtotal", vtotal, 0);
                        check("rst_active", active_px, 0);
                        check("rst_crc", frame_crc, 0);
                        @(negedge sys_clk);
                        sys_reset = 1'b0;
                        expq.delete();
                        aborted = 1'b1;
                    end
                    d  = (f < nfe) && (l >= vde0) && (l < vde0 + vdel) &&
                         (t >= hde0) && (t < hde0 + hdel);
                    p  = (cpix >= 0) ? PW'(cpix) : PW'($urandom);
                    st = 1'b0;
                    if (f == 0 && l == 1 && t == 0) begin
                        nframes = MW'($urandom);
                        st      = 1'b1;
                    end
                    tick(t < hsw, l < vsw, d, p, st, div, ec);
                    if (l == 0 && t == 0) begin
                        if (f > 0 && !aborted) begin
                            e.ht  = (hlen > 4095) ? CW'(4095) : CW'(hlen);
                            e.vt  = CW'(vlen);
                            e.ap  = (2*CW)'(acc_n);
`ifdef VIDMON_CRC_EN
                            e.crc = acc_crc;
`else
                            e.crc = 16'h0000;
`endif
                            e.bsy = (f < nfe);
                            e.cy  = ec;
                            expq.push_back(e);
                        end
                        acc_n   = 0;
                        acc_crc = 16'hFFFF;
                    end
                    if (d) begin
                        acc_n++;
                        acc_crc = crc_model(acc_crc, p);
                    end
                end
            end
        end

        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, '0, 1'b0, div, ec);
        @(negedge sys_clk);
        pix_en = 1'b0;
        @(negedge sys_clk);
        check("done_count", ndone - base, aborted ? 1 : nfe);
        check("queue_empty", expq.size(), 0);
        check("busy_idle", busy, 0);
        check("overflow_end", overflow, (hlen > 4095) ? 1 : 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hl, hs, h0, hd, vl, vs, v0, vd;
        repeat (3) @(negedge sys_clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_htotal", htotal, 0);
        check("reset_vtotal", vtotal, 0);
        check("reset_active", active_px, 0);
        check("reset_crc", frame_crc, 0);
        check("reset_overflow", overflow, 0);
        sys_reset = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Reference raster: 10x7, de 6x4 -> 10/7/24.
        run_case(10, 2, 2, 6, 7, 1, 2, 4, 1, 1, 1, -1, 0);
        run_case(10, 2, 2, 6, 7, 1, 2, 4, 4, 1, 1, -1, 0);
        run_case(10, 2, 2, 6, 7, 1, 2, 4, 1, 3, 1, 'hABC, 0);
        run_case(10, 2, 2, 6, 7, 1, 2, 4, 2, 0, 2, -1, 0);
        // Over-long line: htotal saturates, overflow sticks until next start.
        run_case(5000, 2, 10, 20, 2, 1, 1, 1, 1, 1, 0, -1, 0);
        // Reset in the second of two frames, then a clean capture.
        run_case(10, 2, 2, 6, 7, 1, 2, 4, 1, 2, 1, -1, 1);
        run_case(10, 2, 2, 6, 7, 1, 2, 4, 1, 1, 1, -1, 0);

        for (int i = 0; i < 4; i++) begin
            hl = $urandom_range(8, 24);
            hs = $urandom_range(1, 3);
            h0 = hs + $urandom_range(0, 2);
            hd = $urandom_range(1, hl - h0);
            vl = $urandom_range(5, 9);
            vs = $urandom_range(1, 2);
            v0 = vs + $urandom_range(0, 1);
            vd = $urandom_range(1, vl - v0);
            run_case(hl, hs, h0, hd, vl, vs, v0, vd, $urandom_range(1, 3),
                     $urandom_range(1, 3), $urandom_range(0, 2), -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vid_timing_monitor.md
Name: vid_timing_monitor

Overview:
- Synthesizable video-timing and frame-signature monitor tapping the pixel stream between the VGA timing/pixel path and the output pins.
- Replaces testbench-only VCD/VPI frame inspection with an on-chip measurement.
- Measures horizontal total, vertical total and active-pixel count, and computes a CRC-16 over active pixels for a programmable number of frames.
- Generalised over colour depth, channel count, counter width and sync polarity; results are readable by bench or debug logic.

Parameters:
- COLOR_BITS, 4, bits per colour channel.
- NUM_CH, 3, number of colour channels; pixel word width is COLOR_BITS*NUM_CH.
- CNT_W, 12, width of the pixel and line counters.
- HSYNC_POL, 0, active level of hsync (0 = active-low).
- VSYNC_POL, 0, active level of vsync.
- MAXFRAMES_W, 4, width of the frame-count request.

Ports:
- sys_clk, in, 1, single clock; all logic runs on its rising edge.
- sys_reset, in, 1, asynchronous active-high reset.
- pix_en, in, 1, pixel strobe; all pixel-domain sampling is qualified by it.
- hsync, in, 1, horizontal sync as driven to the pins.
- vsync, in, 1, vertical sync as driven to the pins.
- de, in, 1, active-video (display enable).
- pix, in, COLOR_BITS*NUM_CH, pixel data, channel 0 in the LSBs.
- start, in, 1, one-cycle request to begin capture.
- nframes, in, MAXFRAMES_W, frames to capture; 0 is treated as 1.
- busy, out, 1, capture in progress.
- done, out, 1, one-cycle pulse when results update.
- htotal, out, CNT_W, pix_en ticks between successive hsync leading edges.
- vtotal, out, CNT_W, hsync leading edges between vsync leading edges.
- active_px, out, 2*CNT_W, pixels with de=1 in the last frame.
- frame_crc, out, 16, CRC of the last frame's active pixels.
- overflow, out, 1, sticky; set when any counter saturated.

Behaviour:
- Reset: every output is 0; state is IDLE; sync history registers are cleared to the inactive level.
- Leading-edge detect:
  - On a pix_en cycle, a sync edge occurs when the sampled level is active and the previous pix_en-sampled level was inactive.
  - Inputs are sampled only on pix_en cycles.
- States:
  - IDLE: waits for start. On start, latches nframes (0 becomes 1), sets busy next cycle, goes to ARM.
  - ARM: discards the partial frame. On a vsync leading edge, clears the counters and CRC (seed 0xFFFF) and goes to MEASURE.
  - MEASURE:
    - hcnt increments per pix_en. On an hsync leading edge, hcnt is copied to an htotal shadow, hcnt is set to 1, and vcnt increments.
    - On pix_en with de=1: active counter increments and the CRC absorbs pix (CRC-16-CCITT, poly 0x1021, MSB-first, one full pixel word per step).
    - On a vsync leading edge: htotal/vtotal/active_px/frame_crc load the frame values, done pulses for 1 cycle (the cycle after the edge), the frames-remaining count decrements, and counters/CRC restart for the next frame.
    - When frames remaining reaches 0, goes to IDLE and busy drops in the same cycle as done.
- Simultaneous edges: when hsync and vsync leading edges fall on the same pix_en, the hsync increment is counted into the completing frame before vtotal is loaded.
- Counters saturate at all-ones instead of wrapping, and overflow sets. overflow clears only on the next start or on reset.
- start while busy is ignored.
- Reset mid-capture aborts immediately: no done pulse, outputs return to 0.
- Latency: results are visible 1 sys_clk after the pix_en cycle carrying the vsync edge.
- pix_en held low freezes all measurement state.

Optional Feature:
- Macro: VIDMON_CRC_EN.
- Defined: CRC datapath built; frame_crc behaves as specified above.
- Undefined: no CRC logic is built and frame_crc is held at 0; all other behaviour is unchanged.

Test Plan:
- Synthetic timing with pix_en every cycle: 10-tick lines (hsync low 2, de 6 ticks), 7 lines per frame (vsync low 1 line, de on 4 lines), start with nframes=1 -> done once; htotal=10, vtotal=7, active_px=24, busy drops with done.
- Same timing, pix_en every 4th cycle -> identical htotal/vtotal/active_px; done arrives 4x later in sys_clk.
- nframes=3 with constant pix=12'hABC -> three done pulses with equal frame_crc; this value matches the model CRC of 24 words 0xABC from seed 0xFFFF.
- hsync held inactive for 5000 ticks with CNT_W=12 -> htotal saturates at 4095 and overflow=1; overflow clears on the next start.
- sys_reset asserted during the second frame of nframes=2 -> all outputs 0 immediately, no done; a subsequent start captures normally.
- Build without VIDMON_CRC_EN -> frame_crc=0 in the first scenario, other results unchanged.
